// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL sequencer: state encoding, divider width/reset value
// and the saturating timer increment.
package pll_ctrl_pkg;

    localparam int FBDIV_W = 8;
    localparam logic [FBDIV_W-1:0] FBDIV_RESET = 8'd1;
    localparam int TIMER_W = 13;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_OFF    = 3'd1;
    localparam logic [2:0] ST_ACQ    = 3'd2;
    localparam logic [2:0] ST_LOCKED = 3'd3;
    localparam logic [2:0] ST_RETRY  = 3'd4;
    localparam logic [2:0] ST_FAIL   = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        OFF    = ST_OFF,
        ACQ    = ST_ACQ,
        LOCKED = ST_LOCKED,
        RETRY  = ST_RETRY,
        FAIL   = ST_FAIL
    } state_e;

    function automatic logic [TIMER_W-1:0] timer_inc(input logic [TIMER_W-1:0] t);
        return (t == '1) ? t : t + TIMER_W'(1);
    endfunction

endpackage

// File: rtl/pll_lock_filter.sv
// Brings the raw PLL LOCK into the rclk domain and debounces it: lock_q only follows the
// synchronised level after LOCK_FILTER consecutive agreeing samples.
module pll_lock_filter #(
    parameter int LOCK_FILTER = 8
) (
    input  logic rclk,
    input  logic rst_n,
    input  logic lock_raw,
    output logic lock_q
);

    localparam int CW = $clog2(LOCK_FILTER) + 1;

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= 2'b00;
            cnt    <= '0;
            lock_q <= 1'b0;
        end else begin
            sync <= {sync[0], lock_raw};
            // Any sample that agrees with the current output restarts the run.
            if (sync[1] == lock_q) begin
                cnt <= '0;
            end else if (cnt == CW'(LOCK_FILTER - 1)) begin
                lock_q <= sync[1];
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/pll_seq_ctrl.sv
// PLL sequencer: programs FBDIV with EN low, enables the PLL, qualifies lock and retries a
// bounded number of times before reporting a sticky failure.
module pll_seq_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int OFF_CYCLES   = 8,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int LOCK_FILTER  = 8,
    parameter int MAX_RETRIES  = 3
) (
    input  logic               rclk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    input  logic [FBDIV_W-1:0] cfg_fbdiv,
    output logic               cfg_ready,
    input  logic               stop,
    input  logic               pll_lock,
    output logic               pll_en,
    output logic [FBDIV_W-1:0] pll_fbdiv,
    output logic               locked,
    output logic               fail,
    output logic [1:0]         retry_cnt,
    output logic [2:0]         dbg_state
);

    localparam logic [TIMER_W-1:0] OFF_LAST     = TIMER_W'(OFF_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
    // A lock_q left over from before EN rose needs this long to flush out of the filter.
    localparam logic [TIMER_W-1:0] LOCK_SETTLE  = TIMER_W'(LOCK_FILTER + 2);
    localparam logic [1:0]         RETRY_MAX    = 2'(MAX_RETRIES);

    logic [1:0]         rst_sync;
    logic               rst_int_n;
    logic               lock_q;
    logic               accept;
    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [1:0]         retry_d;
    logic               fail_d;
    logic [FBDIV_W-1:0] fbdiv_q, fbdiv_d;

    // Handshake: a request is taken on any rclk edge where cfg_valid and cfg_ready are both high;
    // cfg_ready depends only on state and stop, never on cfg_valid.
    assign cfg_ready = rst_int_n && !stop &&
                       (state_q == IDLE || state_q == LOCKED || state_q == FAIL);
    assign accept    = cfg_valid && cfg_ready;
    assign dbg_state = state_q;

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    pll_lock_filter #(
        .LOCK_FILTER (LOCK_FILTER)
    ) u_lock_filter (
        .rclk     (rclk),
        .rst_n    (rst_int_n),
        .lock_raw (pll_lock),
        .lock_q   (lock_q)
    );

    always_comb begin
        state_d = state_q;
        retry_d = retry_cnt;
        fail_d  = fail;
        fbdiv_d = fbdiv_q;
        if (accept) begin
            retry_d = '0;
            if (cfg_fbdiv == '0) begin
                fail_d  = 1'b1;
                state_d = FAIL;
            end else begin
                fail_d  = 1'b0;
                fbdiv_d = cfg_fbdiv;
                state_d = OFF;
            end
        end else begin
            case (state_q)
                OFF: begin
                    if (timer_q >= OFF_LAST) state_d = ACQ;
                end
                ACQ: begin
                    if (lock_q && timer_q >= LOCK_SETTLE) state_d = LOCKED;
                    else if (timer_q >= TIMEOUT_LAST)     state_d = RETRY;
                end
                LOCKED: begin
                    if (!lock_q) state_d = RETRY;
                end
                RETRY: begin
                    if (retry_cnt >= RETRY_MAX) begin
                        fail_d  = 1'b1;
                        state_d = FAIL;
                    end else begin
                        retry_d = retry_cnt + 2'd1;
                        state_d = OFF;
                    end
                end
                default: ;
            endcase
        end
        if (stop) state_d = IDLE;
        timer_d = (state_d != state_q) ? '0 : timer_inc(timer_q);
    end

    // Outputs are registered from the next state so EN and locked change on the entry edge.
    always_ff @(posedge rclk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            retry_cnt <= '0;
            fail      <= 1'b0;
            fbdiv_q   <= FBDIV_RESET;
            pll_fbdiv <= FBDIV_RESET;
            pll_en    <= 1'b0;
            locked    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            retry_cnt <= retry_d;
            fail      <= fail_d;
            fbdiv_q   <= fbdiv_d;
            pll_en    <= (state_d == ACQ) || (state_d == LOCKED);
            locked    <= (state_d == LOCKED);
            // EN is already low for the whole OFF state, so the divider moves only then.
            if (state_q == OFF) pll_fbdiv <= fbdiv_q;
        end
    end

endmodule

// File: tb/tb_pll_seq_ctrl.sv
// Bench for pll_seq_ctrl: behavioural PLL lock model, scenario tasks with inline checks and a
// scoreboard of expected divider values consumed whenever locked rises.
module tb_pll_seq_ctrl;
    import pll_ctrl_pkg::*;

    localparam int OFF_CYCLES   = 8;
    localparam int LOCK_TIMEOUT = 4096;
    localparam int LOCK_FILTER  = 8;
    localparam int MAX_RETRIES  = 3;

    localparam int SEL_EN     = 0;
    localparam int SEL_LOCKED = 1;
    localparam int SEL_FAIL   = 2;
    localparam int SEL_LOCK   = 3;

    // {pll_en, pll_fbdiv, locked, fail, retry_cnt, cfg_ready, dbg_state}
    localparam logic [16:0] RST_VEC = {1'b0, 8'd1, 1'b0, 1'b0, 2'd0, 1'b0, ST_IDLE};
    localparam logic [16:0] RDY_VEC = {1'b0, 8'd1, 1'b0, 1'b0, 2'd0, 1'b1, ST_IDLE};

    logic       rclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_fbdiv = 8'd0;
    logic       cfg_ready;
    logic       stop = 1'b0;
    logic       pll_lock = 1'b0;
    logic       pll_en;
    logic [7:0] pll_fbdiv;
    logic       locked;
    logic       fail;
    logic [1:0] retry_cnt;
    logic [2:0] dbg_state;
    logic [16:0] out_vec;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    bit pll_ok = 1'b1;
    int lock_delay = 500;
    int drop_cnt = 0;
    int en_cnt = 0;

    assign out_vec = {pll_en, pll_fbdiv, locked, fail, retry_cnt, cfg_ready, dbg_state};

    always #5 rclk = ~rclk;

    pll_seq_ctrl #(
        .OFF_CYCLES   (OFF_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .LOCK_FILTER  (LOCK_FILTER),
        .MAX_RETRIES  (MAX_RETRIES)
    ) dut (
        .rclk      (rclk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_fbdiv (cfg_fbdiv),
        .cfg_ready (cfg_ready),
        .stop      (stop),
        .pll_lock  (pll_lock),
        .pll_en    (pll_en),
        .pll_fbdiv (pll_fbdiv),
        .locked    (locked),
        .fail      (fail),
        .retry_cnt (retry_cnt),
        .dbg_state (dbg_state)
    );

    // PLL model: LOCK rises lock_delay cycles after EN, drops with EN, can be forced low.
    initial begin
        forever begin
            @(posedge rclk);
            #1;
            if (!pll_en) en_cnt = 0;
            else         en_cnt++;
            pll_lock = pll_ok && pll_en && (en_cnt >= lock_delay) && (drop_cnt == 0);
            if (drop_cnt > 0) drop_cnt--;
        end
    end

    // Scoreboard consumer plus pin-level invariants.
    initial begin
        logic       locked_prev = 1'b0;
        logic       en_prev = 1'b0;
        logic [7:0] fb_prev = 8'd1;
        logic [7:0] exp_fb;
        forever begin
            @(negedge rclk);
            if (locked && !locked_prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_lock: locked rose at fbdiv=%0d with nothing expected", pll_fbdiv);
                end else begin
                    exp_fb = exp_q.pop_front();
                    if (pll_fbdiv !== exp_fb) begin
                        errors++;
                        $display("FAIL sb_lock: fbdiv=%0d expected %0d", pll_fbdiv, exp_fb);
                    end
                end
            end
            if (locked) begin
                checks++;
                if (pll_en !== 1'b1) begin
                    errors++;
                    $display("FAIL locked_without_en: pll_en=%b expected 1", pll_en);
                end
            end
            if (rst_n && pll_fbdiv !== fb_prev) begin
                checks++;
                if (pll_en !== 1'b0 || en_prev !== 1'b0) begin
                    errors++;
                    $display("FAIL fbdiv_while_en: fbdiv %0d->%0d with en %b/%b expected 0/0",
                             fb_prev, pll_fbdiv, en_prev, pll_en);
                end
            end
            locked_prev = locked;
            en_prev     = pll_en;
            fb_prev     = pll_fbdiv;
        end
    end

    initial begin
        #5ms;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    function automatic logic sig(input int sel);
        case (sel)
            SEL_EN:     return pll_en;
            SEL_LOCKED: return locked;
            SEL_FAIL:   return fail;
            default:    return pll_lock;
        endcase
    endfunction

    // Counts rising edges until the selected signal reaches level (sampled 2ns after the edge).
    task automatic count_until(input int sel, input logic level, input int limit, output int n);
        n = 0;
        while (n < limit) begin
            @(posedge rclk);
            n++;
            #2;
            if (sig(sel) === level) break;
        end
    endtask

    // Driver: holds a request until accepted; the accepting edge is the last posedge seen.
    task automatic send_req(input logic [7:0] fb, input bit exp_lock, output bit acc);
        int n = 0;
        acc = 1'b0;
        @(negedge rclk);
        cfg_valid = 1'b1;
        cfg_fbdiv = fb;
        while (!cfg_ready && n < 50) begin
            @(negedge rclk);
            n++;
        end
        if (cfg_ready) begin
            acc = 1'b1;
            if (exp_lock) exp_q.push_back(fb);
        end
        @(posedge rclk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge rclk);
        #2;
        checks++;
        if (out_vec !== RST_VEC) begin
            errors++;
            $display("FAIL reset_hold: outputs=%h expected %h", out_vec, RST_VEC);
        end
        @(negedge rclk);
        rst_n = 1'b1;
        repeat (4) @(posedge rclk);
        #2;
        checks++;
        if (out_vec !== RDY_VEC) begin
            errors++;
            $display("FAIL reset_release: outputs=%h expected %h", out_vec, RDY_VEC);
        end
    endtask

    task automatic test_basic_lock();
        bit acc;
        int n;
        pll_ok = 1'b1;
        lock_delay = 500;
        send_req(8'd20, 1'b1, acc);
        checks++;
        if (!acc) begin errors++; $display("FAIL basic_accept: accepted=%b expected 1", acc); end
        count_until(SEL_EN, 1'b1, 100, n);
        checks++;
        if (n != OFF_CYCLES) begin errors++; $display("FAIL basic_en_delay: %0d edges expected %0d", n, OFF_CYCLES); end
        count_until(SEL_LOCK, 1'b1, 1000, n);
        checks++;
        if (pll_lock !== 1'b1) begin errors++; $display("FAIL basic_pll_lock: lock=%b expected 1", pll_lock); end
        // 2 synchroniser + LOCK_FILTER debounce + 1 registered state, counted from the edge before LOCK rose
        count_until(SEL_LOCKED, 1'b1, 50, n);
        checks++;
        if (n != LOCK_FILTER + 3) begin errors++; $display("FAIL basic_lock_latency: %0d edges expected %0d", n, LOCK_FILTER + 3); end
        checks++;
        if ({retry_cnt, pll_fbdiv, dbg_state} !== {2'd0, 8'd20, ST_LOCKED}) begin
            errors++;
            $display("FAIL basic_status: retry=%0d fbdiv=%0d state=%0d expected 0/20/%0d", retry_cnt, pll_fbdiv, dbg_state, ST_LOCKED);
        end
    endtask

    task automatic test_lock_glitch();
        int n;
        lock_delay = 30;
        @(negedge rclk);
        drop_cnt = 5;
        repeat (30) @(posedge rclk);
        #2;
        checks++;
        if ({locked, retry_cnt, dbg_state} !== {1'b1, 2'd0, ST_LOCKED}) begin
            errors++;
            $display("FAIL glitch_short: locked=%b retry=%0d state=%0d expected 1/0/%0d", locked, retry_cnt, dbg_state, ST_LOCKED);
        end
        exp_q.push_back(8'd20);
        @(negedge rclk);
        drop_cnt = 20;
        // 1 model tick + 2 sync + LOCK_FILTER + 1 registered state
        count_until(SEL_LOCKED, 1'b0, 100, n);
        checks++;
        if (n != LOCK_FILTER + 4) begin errors++; $display("FAIL glitch_long_drop: %0d edges expected %0d", n, LOCK_FILTER + 4); end
        count_until(SEL_LOCKED, 1'b1, 300, n);
        checks++;
        if ({locked, retry_cnt, pll_fbdiv} !== {1'b1, 2'd1, 8'd20}) begin
            errors++;
            $display("FAIL glitch_relock: locked=%b retry=%0d fbdiv=%0d expected 1/1/20", locked, retry_cnt, pll_fbdiv);
        end
    endtask

    task automatic test_reprogram();
        bit acc;
        int n;
        send_req(8'd40, 1'b1, acc);
        checks++;
        if (!acc) begin errors++; $display("FAIL reprog_accept: accepted=%b expected 1", acc); end
        count_until(SEL_EN, 1'b1, 100, n);
        checks++;
        if (n != OFF_CYCLES) begin errors++; $display("FAIL reprog_off_time: %0d edges low expected %0d", n, OFF_CYCLES); end
        checks++;
        if ({pll_fbdiv, retry_cnt} !== {8'd40, 2'd0}) begin
            errors++;
            $display("FAIL reprog_fbdiv: fbdiv=%0d retry=%0d expected 40/0", pll_fbdiv, retry_cnt);
        end
        count_until(SEL_LOCKED, 1'b1, 300, n);
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL reprog_relock: locked=%b expected 1", locked); end
    endtask

    task automatic test_retries();
        bit acc;
        int n;
        pll_ok = 1'b0;
        send_req(8'd30, 1'b0, acc);
        checks++;
        if (!acc) begin errors++; $display("FAIL retry_accept: accepted=%b expected 1", acc); end
        count_until(SEL_EN, 1'b1, 100, n);
        for (int k = 0; k <= MAX_RETRIES; k++) begin
            checks++;
            if (retry_cnt !== 2'(k)) begin errors++; $display("FAIL retry_cnt: %0d expected %0d", retry_cnt, k); end
            count_until(SEL_EN, 1'b0, 5000, n);
            checks++;
            if (n != LOCK_TIMEOUT) begin errors++; $display("FAIL retry_acq_window: %0d edges expected %0d", n, LOCK_TIMEOUT); end
            if (k < MAX_RETRIES) begin
                // one RETRY cycle followed by the OFF period
                count_until(SEL_EN, 1'b1, 100, n);
                checks++;
                if (n != OFF_CYCLES + 1) begin errors++; $display("FAIL retry_off_gap: %0d edges expected %0d", n, OFF_CYCLES + 1); end
            end
        end
        @(posedge rclk);
        #2;
        checks++;
        if (out_vec !== {1'b0, 8'd30, 1'b0, 1'b1, 2'd3, 1'b1, ST_FAIL}) begin
            errors++;
            $display("FAIL retry_exhausted: outputs=%h expected %h", out_vec, {1'b0, 8'd30, 1'b0, 1'b1, 2'd3, 1'b1, ST_FAIL});
        end
    endtask

    task automatic test_stop();
        bit acc;
        int n;
        send_req(8'd50, 1'b0, acc);
        checks++;
        if (!acc || fail !== 1'b0) begin errors++; $display("FAIL stop_req_clears_fail: accepted=%b fail=%b expected 1/0", acc, fail); end
        count_until(SEL_EN, 1'b1, 100, n);
        repeat (5) @(posedge rclk);
        @(negedge rclk);
        stop = 1'b1;
        cfg_valid = 1'b1;
        cfg_fbdiv = 8'd60;
        #1;
        checks++;
        if (cfg_ready !== 1'b0) begin errors++; $display("FAIL stop_ready_low: cfg_ready=%b expected 0", cfg_ready); end
        @(posedge rclk);
        #2;
        checks++;
        if ({pll_en, locked, dbg_state} !== {1'b0, 1'b0, ST_IDLE}) begin
            errors++;
            $display("FAIL stop_to_idle: en=%b locked=%b state=%0d expected 0/0/%0d", pll_en, locked, dbg_state, ST_IDLE);
        end
        repeat (3) @(posedge rclk);
        @(negedge rclk);
        stop = 1'b0;
        cfg_valid = 1'b0;
        repeat (20) @(posedge rclk);
        #2;
        checks++;
        if ({pll_en, pll_fbdiv, dbg_state} !== {1'b0, 8'd50, ST_IDLE}) begin
            errors++;
            $display("FAIL stop_no_accept: en=%b fbdiv=%0d state=%0d expected 0/50/%0d", pll_en, pll_fbdiv, dbg_state, ST_IDLE);
        end
    endtask

    task automatic test_illegal_and_reset();
        bit acc;
        int n;
        send_req(8'd0, 1'b0, acc);
        checks++;
        if ({acc, fail, dbg_state} !== {1'b1, 1'b1, ST_FAIL}) begin
            errors++;
            $display("FAIL illegal_fail: accepted=%b fail=%b state=%0d expected 1/1/%0d", acc, fail, dbg_state, ST_FAIL);
        end
        count_until(SEL_EN, 1'b1, 20, n);
        checks++;
        if (n != 20 || pll_en !== 1'b0) begin errors++; $display("FAIL illegal_no_en: en=%b after %0d edges expected 0 after 20", pll_en, n); end
        @(negedge rclk);
        stop = 1'b1;
        repeat (2) @(posedge rclk);
        #2;
        checks++;
        if ({dbg_state, fail} !== {ST_IDLE, 1'b1}) begin
            errors++;
            $display("FAIL stop_keeps_fail: state=%0d fail=%b expected %0d/1", dbg_state, fail, ST_IDLE);
        end
        @(negedge rclk);
        stop = 1'b0;
        pll_ok = 1'b1;
        lock_delay = 1000;
        send_req(8'd20, 1'b0, acc);
        checks++;
        if (!acc || fail !== 1'b0) begin errors++; $display("FAIL reset_req_accept: accepted=%b fail=%b expected 1/0", acc, fail); end
        count_until(SEL_EN, 1'b1, 100, n);
        repeat (10) @(posedge rclk);
        @(negedge rclk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_vec !== RST_VEC) begin errors++; $display("FAIL reset_mid_acq: outputs=%h expected %h", out_vec, RST_VEC); end
        repeat (2) @(negedge rclk);
        rst_n = 1'b1;
        repeat (4) @(posedge rclk);
        #2;
        checks++;
        if (out_vec !== RDY_VEC) begin errors++; $display("FAIL reset_mid_release: outputs=%h expected %h", out_vec, RDY_VEC); end
    endtask

    initial begin
        test_reset();
        test_basic_lock();
        test_lock_glitch();
        test_reprogram();
        test_retries();
        test_stop();
        test_illegal_and_reset();
        repeat (5) @(posedge rclk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d expected locks outstanding, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
